// File: rtl/audio_lpf_decimate.sv
// Audio low-pass FIR with integer decimation: pops DECIM samples, then runs a
// one-tap-per-cycle MAC over the TAPS-deep history and pushes one output.
module audio_lpf_decimate #(
  parameter int                 TAPS      = 32,
  parameter int                 DECIM     = 8,
  parameter int                 FRAC_BITS = 10,
  parameter logic signed [31:0] COEFFS [0:TAPS-1] = '{default: 32'sd0}
) (
  input  logic        clock,
  input  logic        reset,
  output logic        in_rd_en,
  input  logic        in_empty,
  input  logic [31:0] in_dout,
  output logic        out_wr_en,
  input  logic        out_full,
  output logic [31:0] out_din
);

  localparam int TW = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int CW = $clog2(DECIM + 1);

  typedef enum logic [1:0] {S_LOAD, S_MAC, S_WRITE} state_e;

  state_e             state_q, state_d;
  logic signed [31:0] x_q [TAPS];
  logic [CW-1:0]      count_q, count_d;
  logic [TW-1:0]      tap_q, tap_d;
  logic signed [31:0] acc_q, acc_d;

  logic               last_pop, last_tap;
  logic signed [63:0] prod;
  logic signed [31:0] term;

  assign last_pop = in_rd_en && (count_q == CW'(DECIM - 1));
  assign last_tap = (tap_q == TW'(TAPS - 1));

  // Full 64-bit product, arithmetic shift (floor), then keep the low word.
  assign prod = 64'(x_q[tap_q]) * 64'(COEFFS[tap_q]);
  assign term = 32'(prod >>> FRAC_BITS);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_LOAD;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LOAD:  if (last_pop)   state_d = S_MAC;
      S_MAC:   if (last_tap)   state_d = S_WRITE;
      S_WRITE: if (!out_full)  state_d = S_LOAD;
      default:                 state_d = S_LOAD;
    endcase
  end

  // Strobes are held low while reset is asserted even though the state is LOAD.
  always_comb begin
    in_rd_en  = 1'b0;
    out_wr_en = 1'b0;
    out_din   = '0;
    if (!reset) begin
      case (state_q)
        S_LOAD:  in_rd_en = !in_empty;
        S_WRITE: begin
          out_wr_en = !out_full;
          out_din   = acc_q;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    count_d = count_q;
    tap_d   = tap_q;
    acc_d   = acc_q;
    case (state_q)
      S_LOAD: begin
        if (last_pop) begin
          count_d = '0;
          tap_d   = '0;
          acc_d   = '0;
        end else if (in_rd_en) begin
          count_d = count_q + CW'(1);
        end
      end
      S_MAC: begin
        acc_d = acc_q + term;
        if (!last_tap) tap_d = tap_q + TW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      tap_q   <= '0;
      acc_q   <= '0;
    end else begin
      count_q <= count_d;
      tap_q   <= tap_d;
      acc_q   <= acc_d;
    end
  end

  // History shift register, x_q[0] newest; only moves on a pop.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < TAPS; i++) x_q[i] <= '0;
    end else if (in_rd_en) begin
      x_q[0] <= $signed(in_dout);
      for (int i = 1; i < TAPS; i++) x_q[i] <= x_q[i-1];
    end
  end

endmodule

// File: tb/tb_audio_lpf_decimate.sv
// Bench for audio_lpf_decimate: three instances with different coefficient
// sets share stimulus; a reference model queues expected outputs per instance.
module tb_audio_lpf_decimate;
  localparam int TAPS  = 4;
  localparam int DECIM = 2;
  localparam int FRAC  = 10;
  localparam logic signed [31:0] CA [0:TAPS-1] = '{32'sd1024, 32'sd2048, 32'sd3072, 32'sd4096};
  localparam logic signed [31:0] CB [0:TAPS-1] = '{32'sd1, 32'sd1, 32'sd1, 32'sd1};
  localparam logic signed [31:0] CC [0:TAPS-1] = '{32'sd1024, 32'sd1024, 32'sd1024, 32'sd1024};

  logic        clock = 1'b0;
  logic        reset;
  logic        in_empty, out_full;
  logic [31:0] in_dout;
  logic [2:0]  rd, wr;
  logic [31:0] dout [3];

  audio_lpf_decimate #(.TAPS(TAPS), .DECIM(DECIM), .FRAC_BITS(FRAC), .COEFFS(CA)) u_a (
    .clock(clock), .reset(reset), .in_rd_en(rd[0]), .in_empty(in_empty), .in_dout(in_dout),
    .out_wr_en(wr[0]), .out_full(out_full), .out_din(dout[0]));
  audio_lpf_decimate #(.TAPS(TAPS), .DECIM(DECIM), .FRAC_BITS(FRAC), .COEFFS(CB)) u_b (
    .clock(clock), .reset(reset), .in_rd_en(rd[1]), .in_empty(in_empty), .in_dout(in_dout),
    .out_wr_en(wr[1]), .out_full(out_full), .out_din(dout[1]));
  audio_lpf_decimate #(.TAPS(TAPS), .DECIM(DECIM), .FRAC_BITS(FRAC), .COEFFS(CC)) u_c (
    .clock(clock), .reset(reset), .in_rd_en(rd[2]), .in_empty(in_empty), .in_dout(in_dout),
    .out_wr_en(wr[2]), .out_full(out_full), .out_din(dout[2]));

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int last_pop_cyc, push_cyc;
  int n_push0 = 0;

  always @(posedge clock) cyc <= cyc + 1;

  logic signed [31:0] cf   [3][TAPS];
  logic signed [31:0] hist [3][TAPS];
  int                 mcnt;
  logic signed [31:0] expq [3][$];
  logic signed [31:0] got  [3][$];

  function automatic logic signed [31:0] fir(input int d);
    logic signed [31:0] acc;
    logic signed [63:0] p;
    acc = 0;
    for (int i = 0; i < TAPS; i++) begin
      p   = 64'(hist[d][i]) * 64'(cf[d][i]);
      acc = acc + 32'(p >>> FRAC);
    end
    return acc;
  endfunction

  task automatic model_pop(input logic signed [31:0] v);
    for (int d = 0; d < 3; d++) begin
      for (int i = TAPS - 1; i > 0; i--) hist[d][i] = hist[d][i-1];
      hist[d][0] = v;
    end
    mcnt++;
    if (mcnt == DECIM) begin
      mcnt = 0;
      for (int d = 0; d < 3; d++) expq[d].push_back(fir(d));
    end
  endtask

  task automatic model_reset();
    mcnt = 0;
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < TAPS; i++) hist[d][i] = '0;
      expq[d].delete();
      got[d].delete();
    end
  endtask

  // Scoreboard: every push is matched against the next queued expectation.
  always @(negedge clock) begin
    if (!reset) begin
      for (int d = 0; d < 3; d++) begin
        if (wr[d]) begin
          n_tests++;
          if (expq[d].size() == 0) begin
            n_fail++;
            $display("FAIL push_dut%0d unexpected push out_din=%0d, required no push", d, $signed(dout[d]));
          end else if ($signed(dout[d]) !== expq[d][0]) begin
            n_fail++;
            $display("FAIL push_dut%0d out_din=%0d required %0d", d, $signed(dout[d]), expq[d][0]);
            void'(expq[d].pop_front());
          end else begin
            void'(expq[d].pop_front());
          end
          got[d].push_back($signed(dout[d]));
          if (d == 0) begin
            push_cyc = cyc;
            n_push0++;
          end
        end
      end
    end
  end

  task automatic feed(input logic signed [31:0] v);
    bit ok;
    ok = 1'b0;
    @(posedge clock); #1;
    in_dout  = v;
    in_empty = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clock);
      if (rd[0]) ok = 1'b1;
    end
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL feed_timeout in_rd_en=0 required 1 within 200 cycles");
    end else begin
      last_pop_cyc = cyc;
      model_pop(v);
    end
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    @(posedge clock); #1;
    in_empty = 1'b1;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clock);
      if (expq[0].size() == 0 && expq[1].size() == 0 && expq[2].size() == 0) done = 1'b1;
    end
    n_tests++;
    if (!done) begin
      n_fail++;
      $display("FAIL drain pending=%0d/%0d/%0d required 0", expq[0].size(), expq[1].size(), expq[2].size());
    end
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset    = 1'b1;
    in_empty = 1'b1;
    out_full = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    @(negedge clock);
    n_tests++;
    if (rd !== 3'b000 || wr !== 3'b000 || dout[0] !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_strobes rd=%b wr=%b out_din=%0d required 000 000 0", rd, wr, dout[0]);
    end
    @(posedge clock); #1;
    reset    = 1'b0;
    in_empty = 1'b1;
    model_reset();
    @(negedge clock);
    n_tests++;
    if (rd !== 3'b000 || wr !== 3'b000 || dout[0] !== 32'd0) begin
      n_fail++;
      $display("FAIL idle_after_reset rd=%b wr=%b out_din=%0d required 000 000 0", rd, wr, dout[0]);
    end
  endtask

  task automatic test_impulse();
    logic signed [31:0] req [3];
    req = '{32'sd2048, 32'sd4096, 32'sd0};
    do_reset();
    feed(32'sd1024);
    for (int i = 0; i < 5; i++) feed(32'sd0);
    drain();
    n_tests++;
    if (got[0].size() != 3) begin
      n_fail++;
      $display("FAIL impulse_count outputs=%0d required 3", got[0].size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_tests++;
        if (got[0][i] !== req[i]) begin
          n_fail++;
          $display("FAIL impulse_out%0d got %0d required %0d", i, got[0][i], req[i]);
        end
      end
    end
  endtask

  task automatic test_dc();
    do_reset();
    for (int i = 0; i < 20; i++) feed(32'sd1024);
    drain();
    n_tests++;
    if (got[0].size() != 10) begin
      n_fail++;
      $display("FAIL dc_count outputs=%0d required 10", got[0].size());
    end else begin
      for (int i = 0; i < 10; i++) begin
        n_tests++;
        if (got[0][i] !== ((i == 0) ? 32'sd3072 : 32'sd10240)) begin
          n_fail++;
          $display("FAIL dc_out%0d got %0d required %0d", i, got[0][i], (i == 0) ? 3072 : 10240);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int pushes;
    @(posedge clock); #1;
    out_full = 1'b1;
    feed(32'sd2000);
    feed(-32'sd500);
    @(posedge clock); #1;
    in_dout = 32'd777;
    repeat (TAPS) @(posedge clock);
    #1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      n_tests++;
      if (rd[0] !== 1'b0 || wr[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL hold%0d rd=%b wr=%b required 0 0", i, rd[0], wr[0]);
      end
      n_tests++;
      if (expq[0].size() == 0 || $signed(dout[0]) !== expq[0][0]) begin
        n_fail++;
        $display("FAIL hold_value%0d out_din=%0d required %0d", i, $signed(dout[0]),
                 (expq[0].size() == 0) ? 0 : expq[0][0]);
      end
    end
    @(posedge clock); #1;
    out_full = 1'b0;
    pushes   = n_push0;
    feed(32'sd777);
    n_tests++;
    if (n_push0 - pushes != 1) begin
      n_fail++;
      $display("FAIL release_push pushes=%0d required 1", n_push0 - pushes);
    end
    drain();
  endtask

  task automatic test_sparse();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      feed(32'sd1024);
      @(posedge clock); #1;
      in_empty = 1'b1;
    end
    drain();
    n_tests++;
    if (push_cyc - last_pop_cyc != TAPS + 1) begin
      n_fail++;
      $display("FAIL sparse_latency got %0d cycles required %0d", push_cyc - last_pop_cyc, TAPS + 1);
    end
    n_tests++;
    if (got[0].size() != 10) begin
      n_fail++;
      $display("FAIL sparse_count outputs=%0d required 10", got[0].size());
    end else begin
      for (int i = 0; i < 10; i++) begin
        n_tests++;
        if (got[0][i] !== ((i == 0) ? 32'sd3072 : 32'sd10240)) begin
          n_fail++;
          $display("FAIL sparse_out%0d got %0d required %0d", i, got[0][i], (i == 0) ? 3072 : 10240);
        end
      end
    end
  endtask

  task automatic test_sign_wrap();
    do_reset();
    for (int i = 0; i < 6; i++) feed(-32'sd1);
    drain();
    n_tests++;
    if (got[1].size() != 3 || got[1][0] !== -32'sd2 || got[1][1] !== -32'sd4 || got[1][2] !== -32'sd4) begin
      n_fail++;
      $display("FAIL sign_floor outputs=%0d last=%0d required 3 outputs -2,-4,-4", got[1].size(),
               (got[1].size() == 0) ? 0 : got[1][got[1].size()-1]);
    end
    do_reset();
    for (int i = 0; i < 4; i++) feed(32'sh7fff_ffff);
    drain();
    n_tests++;
    if (got[2].size() != 2 || got[2][0] !== -32'sd2 || got[2][1] !== -32'sd4) begin
      n_fail++;
      $display("FAIL wrap outputs=%0d last=%0d required 2 outputs -2,-4", got[2].size(),
               (got[2].size() == 0) ? 0 : got[2][got[2].size()-1]);
    end
  endtask

  task automatic test_reset_mac();
    do_reset();
    feed(32'sd5000);
    feed(32'sd7000);
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset    = 1'b1;
    in_empty = 1'b0;
    @(negedge clock);
    n_tests++;
    if (rd !== 3'b000 || wr !== 3'b000 || dout[0] !== 32'd0) begin
      n_fail++;
      $display("FAIL mac_reset_strobes rd=%b wr=%b out_din=%0d required 000 000 0", rd, wr, dout[0]);
    end
    @(posedge clock); #1;
    reset    = 1'b0;
    in_empty = 1'b1;
    model_reset();
    repeat (TAPS + 3) @(posedge clock);
    feed(32'sd1024);
    feed(32'sd0);
    drain();
    n_tests++;
    if (got[0].size() != 1 || got[0][0] !== 32'sd2048) begin
      n_fail++;
      $display("FAIL mac_reset_restart outputs=%0d first=%0d required 1 output 2048", got[0].size(),
               (got[0].size() == 0) ? 0 : got[0][0]);
    end
  endtask

  initial begin
    reset    = 1'b1;
    in_empty = 1'b0;
    out_full = 1'b0;
    in_dout  = '0;
    for (int i = 0; i < TAPS; i++) begin
      cf[0][i] = CA[i];
      cf[1][i] = CB[i];
      cf[2][i] = CC[i];
    end
    model_reset();
    test_reset();
    test_impulse();
    test_dc();
    test_backpressure();
    test_sparse();
    test_sign_wrap();
    test_reset_mac();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
